pll_lock_monitor: RTL and testbench



---
 rtl/pll_mon_pkg.sv | 22 ++
 rtl/pll_lock_chan.sv | 135 +++++++++++++
 rtl/pll_lock_monitor.sv | 58 +++++
 tb/tb_pll_lock_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and width helpers for the PLL lock monitor.
// Channel FSM encoding plus the counter-width function used for timer and filter sizing.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    LOCKED    = 2'd1,
    LOST      = 2'd2,
    TIMEOUT   = 2'd3
  } chan_state_e;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One monitored PLL: synchroniser, debounce filter, lock FSM with acquisition timer,
// sticky error flags and a saturating lock-loss counter.
//
// state     | meaning
// WAIT_LOCK | timer running, lock not yet accepted since reset/clr
// LOCKED    | debounced lock present
// LOST      | lock dropped after acceptance, timer running for reacquisition
// TIMEOUT   | lock not accepted in time, timer frozen
module pll_lock_chan
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clr,
  output logic             lock_ok,
  output logic             lock_rise,
  output logic             err_loss,
  output logic             err_timeout,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int FILT_W  = clog2(FILT_CYCLES + 1);
  localparam int TIMER_W = clog2(LOCK_TIMEOUT);
  localparam logic [FILT_W-1:0]  FILT_MAX   = FILT_W'(FILT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      filt_q, filt_d;
  logic                   lock_ok_q, lock_ok_d;
  chan_state_e            state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   lock_rise_q, lock_rise_d;
  logic                   err_loss_q, err_loss_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock};
    filt_d = '0;
    if (s) filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + FILT_W'(1);
    // Gating with s makes lock_ok fall on the first low synced sample.
    lock_ok_d = s && (filt_q == FILT_MAX);
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    lock_rise_d   = 1'b0;
    err_loss_d    = err_loss_q;
    err_timeout_d = err_timeout_q;
    loss_cnt_d    = loss_cnt_q;

    if (clr) begin
      err_loss_d    = 1'b0;
      err_timeout_d = 1'b0;
      loss_cnt_d    = '0;
      timer_d       = '0;
      if (state_q == TIMEOUT) state_d = WAIT_LOCK;
    end

    // Events are applied after the clear so they win when both happen together.
    case (state_q)
      WAIT_LOCK, LOST: begin
        if (lock_ok_q) begin
          state_d     = LOCKED;
          timer_d     = '0;
          lock_rise_d = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = TIMEOUT;
          err_timeout_d = 1'b1;
        end else if (!clr) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      LOCKED: begin
        if (!lock_ok_q) begin
          state_d    = LOST;
          timer_d    = '0;
          err_loss_d = 1'b1;
          if (clr) loss_cnt_d = CNT_W'(1);
          else if (loss_cnt_q != CNT_MAX) loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end
      end
      TIMEOUT: begin
        if (lock_ok_q) begin
          state_d     = LOCKED;
          timer_d     = '0;
          lock_rise_d = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      filt_q        <= '0;
      lock_ok_q     <= 1'b0;
      state_q       <= WAIT_LOCK;
      timer_q       <= '0;
      lock_rise_q   <= 1'b0;
      err_loss_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      loss_cnt_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      filt_q        <= filt_d;
      lock_ok_q     <= lock_ok_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      lock_rise_q   <= lock_rise_d;
      err_loss_q    <= err_loss_d;
      err_timeout_q <= err_timeout_d;
      loss_cnt_q    <= loss_cnt_d;
    end
  end

  assign lock_ok     = lock_ok_q;
  assign lock_rise   = lock_rise_q;
  assign err_loss    = err_loss_q;
  assign err_timeout = err_timeout_q;
  assign loss_cnt    = loss_cnt_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Lock supervisor for NCH PLL instances: one independent pll_lock_chan per input,
// plus the aggregate lock_all and registered err_any summary.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int NCH          = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       pll_lock,
  input  logic                 clr,
  output logic [NCH-1:0]       lock_ok,
  output logic                 lock_all,
  output logic [NCH-1:0]       lock_rise,
  output logic [NCH-1:0]       err_loss,
  output logic [NCH-1:0]       err_timeout,
  output logic [NCH*CNT_W-1:0] loss_cnt,
  output logic                 err_any
);

  logic err_any_q, err_any_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pll_lock_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_lock   (pll_lock[i]),
      .clr        (clr),
      .lock_ok    (lock_ok[i]),
      .lock_rise  (lock_rise[i]),
      .err_loss   (err_loss[i]),
      .err_timeout(err_timeout[i]),
      .loss_cnt   (loss_cnt[i*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    err_any_d = |(err_loss | err_timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_any_q <= 1'b0;
    else        err_any_q <= err_any_d;
  end

  assign lock_all = &lock_ok;
  assign err_any  = err_any_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: a behavioural model predicts every output
// after each clock edge; a negedge monitor pops and compares against the DUT.
module tb_pll_lock_monitor;

  localparam int NCH = 3;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 4;
  localparam int LOCK_TIMEOUT = 64;
  localparam int CNT_W = 3;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int SW = 4 * NCH + NCH * CNT_W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] pll_lock = '0;
  logic clr = 1'b0;
  logic [NCH-1:0] lock_ok, lock_rise, err_loss, err_timeout;
  logic lock_all, err_any;
  logic [NCH*CNT_W-1:0] loss_cnt;
  logic [SW-1:0] dut_vec;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .NCH(NCH), .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clr(clr),
    .lock_ok(lock_ok), .lock_all(lock_all), .lock_rise(lock_rise),
    .err_loss(err_loss), .err_timeout(err_timeout), .loss_cnt(loss_cnt),
    .err_any(err_any)
  );

  assign dut_vec = {lock_ok, lock_all, lock_rise, err_loss, err_timeout, loss_cnt, err_any};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: lock is accepted once the raw input has been high for
  // FILT_CYCLES+1 consecutive samples, seen SYNC_STAGES edges later.
  int run_len [NCH];
  int run_dly [NCH][$];
  bit m_lo [NCH];
  bit m_locked [NCH];
  bit m_timed_out [NCH];
  int m_wait [NCH];
  bit m_el [NCH];
  bit m_et [NCH];
  int m_cnt [NCH];
  bit m_any;
  logic [SW-1:0] exp_q [$];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      run_len[c] = 0;
      run_dly[c].delete();
      for (int k = 0; k <= SYNC_STAGES; k++) run_dly[c].push_back(0);
      m_lo[c] = 0; m_locked[c] = 0; m_timed_out[c] = 0; m_wait[c] = 0;
      m_el[c] = 0; m_et[c] = 0; m_cnt[c] = 0;
    end
    m_any = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NCH-1:0] e_lo, e_rise, e_el, e_et;
    logic [NCH*CNT_W-1:0] e_cnt;
    bit any_next, ev_rise, ev_loss, ev_to;
    any_next = 0;
    for (int c = 0; c < NCH; c++) any_next = any_next | m_el[c] | m_et[c];
    for (int c = 0; c < NCH; c++) begin
      ev_rise = !m_locked[c] && m_lo[c];
      ev_loss = m_locked[c] && !m_lo[c];
      ev_to = !m_locked[c] && !m_timed_out[c] && !m_lo[c] && (m_wait[c] == LOCK_TIMEOUT - 1);
      if (clr) begin
        m_el[c] = 0; m_et[c] = 0; m_cnt[c] = 0; m_wait[c] = 0; m_timed_out[c] = 0;
      end else if (!m_locked[c] && !m_timed_out[c]) begin
        m_wait[c]++;
      end
      e_rise[c] = 1'b0;
      if (ev_rise) begin
        m_locked[c] = 1; m_timed_out[c] = 0; m_wait[c] = 0; e_rise[c] = 1'b1;
      end else if (ev_loss) begin
        m_locked[c] = 0; m_wait[c] = 0; m_el[c] = 1;
        m_cnt[c] = (m_cnt[c] < MAXC) ? m_cnt[c] + 1 : MAXC;
      end else if (ev_to) begin
        m_timed_out[c] = 1; m_et[c] = 1;
      end
      run_len[c] = pll_lock[c] ? ((run_len[c] < 1000) ? run_len[c] + 1 : 1000) : 0;
      run_dly[c].push_back(run_len[c]);
      void'(run_dly[c].pop_front());
      m_lo[c] = (run_dly[c][0] >= FILT_CYCLES + 1);
      e_lo[c] = m_lo[c];
      e_el[c] = m_el[c];
      e_et[c] = m_et[c];
      e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    end
    m_any = any_next;
    exp_q.push_back({e_lo, &e_lo, e_rise, e_el, e_et, e_cnt, m_any});
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [SW-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("snapshot@%0d", cyc), 32'(dut_vec), 32'(e));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts edges after reset release until all channels report lock.
  task automatic check_relock_latency(input string name);
    int k;
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (lock_ok == '1) begin
        k = i;
        break;
      end
    end
    check(name, 32'(k), 32'(SYNC_STAGES + FILT_CYCLES));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold [NCH];
    repeat (3) @(posedge clk);
    #2 pll_lock = '1;
    #5 rst_n = 1'b1;
    check_relock_latency("rise_latency");
    tick(10);

    pll_lock[1] = 1'b0; tick(10);
    pll_lock[1] = 1'b1; tick(15);
    check("ch1_loss_cnt", 32'(loss_cnt[1*CNT_W +: CNT_W]), 32'd1);

    for (int r = 0; r < 15; r++) begin
      pll_lock[0] = 1'b1; tick(3);
      pll_lock[0] = 1'b0; tick(3);
    end
    check("ch0_timeout", 32'(err_timeout[0]), 32'd1);
    pll_lock[0] = 1'b1; tick(15);
    check("ch0_relock_after_timeout", 32'({lock_ok[0], err_timeout[0]}), 32'b11);

    for (int r = 0; r < 9; r++) begin
      pll_lock[2] = 1'b0; tick(4);
      pll_lock[2] = 1'b1; tick(10);
    end
    check("ch2_cnt_saturated", 32'(loss_cnt[2*CNT_W +: CNT_W]), 32'(MAXC));
    clr = 1'b1; tick(1);
    clr = 1'b0; tick(1);
    check("ch2_after_clr", 32'({err_loss[2], loss_cnt[2*CNT_W +: CNT_W]}), 32'd0);

    tick(5);
    pll_lock[1] = 1'b0; tick(3);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    check("clr_vs_loss", 32'({err_loss[1], loss_cnt[1*CNT_W +: CNT_W]}), 32'b1001);
    pll_lock[1] = 1'b1; tick(15);

    for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 80);
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          pll_lock[c] = ~pll_lock[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 90);
        end
      end
      clr = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    clr = 1'b0;

    pll_lock = '1; tick(20);
    @(posedge clk);
    #7 rst_n = 1'b0;
    #1 check("reset_outputs", 32'(dut_vec), 32'd0);
    @(posedge clk);
    #7 rst_n = 1'b1;
    check_relock_latency("relock_after_reset");
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
